// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 68000 bus cycle sequencer.
// Generates DTACK for internally timed ROM/RAM cycles, forwards peripheral
// DTACK for DUART/MFP/interrupt-acknowledge cycles and raises BERR when a
// cycle is not acknowledged within TIMEOUT_CYCLES clock edges.
module bus_cycle_ctrl #(
    parameter int unsigned ROM_WS         = 2,
    parameter int unsigned RAM_WS         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       IACK,
    input  logic       ROMEN,
    input  logic       RAMEN,
    input  logic       DUARTEN,
    input  logic       MFPEN,
    input  logic       DUART_DTACK_IN,
    input  logic       MFP_DTACK_IN,
    output logic       DTACK,
    output logic       BERR,
    output logic       TIMEOUT_SEEN,
    output logic [7:0] ERR_COUNT
);

    // Bus cycle states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Cycle classes latched at cycle start
    localparam logic [1:0] C_INT      = 2'd0;
    localparam logic [1:0] C_DUART    = 2'd1;
    localparam logic [1:0] C_MFP      = 2'd2;
    localparam logic [1:0] C_UNMAPPED = 2'd3;

    localparam logic [3:0] ROM_WAIT = 4'(ROM_WS);
    localparam logic [3:0] RAM_WAIT = 4'(RAM_WS);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [1:0] r_state;
    logic [1:0] r_class;
    logic [3:0] r_wait_cnt;
    logic [7:0] r_to_cnt;
    logic       r_timeout_seen;
    logic [7:0] r_err_count;

    logic [1:0] w_state_next;
    logic [1:0] w_class_next;
    logic [3:0] w_wait_next;
    logic [7:0] w_to_next;
    logic [1:0] w_start_class;
    logic [3:0] w_start_wait;
    logic       w_ack_cond;
    logic       w_timeout;
    logic       w_enter_err;

    // Priority decode of the cycle class from IACK and the chip selects
    always_comb begin
        w_start_class = C_UNMAPPED;
        w_start_wait  = 4'd0;
        if (!IACK) begin
            w_start_class = C_MFP;
        end else if (!ROMEN) begin
            w_start_class = C_INT;
            w_start_wait  = ROM_WAIT;
        end else if (!RAMEN) begin
            w_start_class = C_INT;
            w_start_wait  = RAM_WAIT;
        end else if (!DUARTEN) begin
            w_start_class = C_DUART;
        end else if (!MFPEN) begin
            w_start_class = C_MFP;
        end
    end

    // Acknowledge condition for the latched class; only the peripheral
    // belonging to the cycle can terminate it
    always_comb begin
        w_ack_cond = 1'b0;
        case (r_class)
            C_INT:   w_ack_cond = (r_wait_cnt == 4'd1);
            C_DUART: w_ack_cond = !DUART_DTACK_IN;
            C_MFP:   w_ack_cond = !MFP_DTACK_IN;
            default: w_ack_cond = 1'b0;
        endcase
    end

    // r_to_cnt holds k on WAIT edge N+k, so BERR follows edge N+TIMEOUT_CYCLES
    assign w_timeout = (r_to_cnt == TO_LIMIT);

    // Next-state and counter update logic
    always_comb begin
        w_state_next = r_state;
        w_class_next = r_class;
        w_wait_next  = r_wait_cnt;
        w_to_next    = r_to_cnt;
        case (r_state)
            S_IDLE: begin
                if (!AS) begin
                    w_class_next = w_start_class;
                    w_wait_next  = w_start_wait;
                    w_to_next    = 8'd1;
                    if ((w_start_class == C_INT) && (w_start_wait == 4'd0)) begin
                        w_state_next = S_ACK;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (AS) begin
                    // CPU abandoned the cycle: no ack, no error
                    w_state_next = S_IDLE;
                end else if (w_ack_cond) begin
                    // Ack beats a timeout falling on the same edge
                    w_state_next = S_ACK;
                end else if (w_timeout) begin
                    w_state_next = S_ERR;
                end else begin
                    w_to_next = r_to_cnt + 8'd1;
                    if (r_wait_cnt != 4'd0) begin
                        w_wait_next = r_wait_cnt - 4'd1;
                    end
                end
            end
            S_ACK, S_ERR: begin
                if (AS) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_enter_err = (r_state == S_WAIT) && (w_state_next == S_ERR);

    // State and counter registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_class    <= C_UNMAPPED;
            r_wait_cnt <= 4'd0;
            r_to_cnt   <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_class    <= w_class_next;
            r_wait_cnt <= w_wait_next;
            r_to_cnt   <= w_to_next;
        end
    end

    // Sticky timeout flag and saturating error counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_timeout_seen <= 1'b0;
            r_err_count    <= 8'd0;
        end else if (w_enter_err) begin
            r_timeout_seen <= 1'b1;
            if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    // Outputs decoded from registered state only
    assign DTACK        = (r_state != S_ACK);
    assign BERR         = (r_state != S_ERR);
    assign TIMEOUT_SEEN = r_timeout_seen;
    assign ERR_COUNT    = r_err_count;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Testbench for bus_cycle_ctrl (ROM_WS=2, RAM_WS=0, TIMEOUT_CYCLES=64).
// Table of bus cycles with expected outcome/latency, scoreboarded through a
// queue, plus hand-written abort, saturation and reset sequences.
module tb_bus_cycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       AS = 1'b1;
    logic       IACK = 1'b1;
    logic       ROMEN = 1'b1;
    logic       RAMEN = 1'b1;
    logic       DUARTEN = 1'b1;
    logic       MFPEN = 1'b1;
    logic       DUART_DTACK_IN = 1'b1;
    logic       MFP_DTACK_IN = 1'b1;
    logic       DTACK;
    logic       BERR;
    logic       TIMEOUT_SEEN;
    logic [7:0] ERR_COUNT;

    bus_cycle_ctrl #(
        .ROM_WS(2),
        .RAM_WS(0),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .AS(AS),
        .IACK(IACK),
        .ROMEN(ROMEN),
        .RAMEN(RAMEN),
        .DUARTEN(DUARTEN),
        .MFPEN(MFPEN),
        .DUART_DTACK_IN(DUART_DTACK_IN),
        .MFP_DTACK_IN(MFP_DTACK_IN),
        .DTACK(DTACK),
        .BERR(BERR),
        .TIMEOUT_SEEN(TIMEOUT_SEEN),
        .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    // ack_src: 0 none, 1 DUART, 2 MFP; ack_at: edge offset at which the
    // source DTACK is first sampled low (0 = already low when AS falls)
    typedef struct {
        string name;
        bit    iack;
        bit    romen;
        bit    ramen;
        bit    duarten;
        bit    mfpen;
        int    ack_src;
        int    ack_at;
        bit    toggle_mfp;
        bit    drop_sel;
        bit    exp_err;
        int    exp_lat;
    } vec_t;

    typedef struct {
        bit err;
        int lat;
    } exp_t;

    localparam int BOUND = 200;

    vec_t vecs[12];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   exp_cnt = 0;
    int   exp_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %0s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic release_bus();
        AS = 1'b1; IACK = 1'b1; ROMEN = 1'b1; RAMEN = 1'b1;
        DUARTEN = 1'b1; MFPEN = 1'b1;
        DUART_DTACK_IN = 1'b1; MFP_DTACK_IN = 1'b1;
    endtask

    task automatic run_cycle(input vec_t v);
        exp_t e;
        int   k;
        bit   done;
        bit   got_err;
        @(negedge CLK);
        IACK = v.iack; ROMEN = v.romen; RAMEN = v.ramen;
        DUARTEN = v.duarten; MFPEN = v.mfpen;
        DUART_DTACK_IN = !(v.ack_src == 1 && v.ack_at == 0);
        MFP_DTACK_IN   = !(v.ack_src == 2 && v.ack_at == 0);
        AS = 1'b0;
        e.err = v.exp_err;
        e.lat = v.exp_lat;
        sb_q.push_back(e);
        done = 1'b0; got_err = 1'b0; k = 0;
        while (!done && k <= BOUND) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DTACK == 1'b0 || BERR == 1'b0) begin
                done = 1'b1;
                got_err = (BERR == 1'b0);
            end else begin
                if (k == 0 && v.drop_sel) begin
                    ROMEN = 1'b1; RAMEN = 1'b0; DUARTEN = 1'b0; MFPEN = 1'b0;
                end
                if (v.toggle_mfp) MFP_DTACK_IN = ~MFP_DTACK_IN;
                if (v.ack_src == 1 && k + 1 >= v.ack_at) DUART_DTACK_IN = 1'b0;
                if (v.ack_src == 2 && k + 1 >= v.ack_at) MFP_DTACK_IN = 1'b0;
                k++;
            end
        end
        e = sb_q.pop_front();
        if (!done) begin
            check({v.name, " response_bound"}, 0, 1);
        end else begin
            if (e.err) begin
                exp_seen = 1;
                if (exp_cnt < 255) exp_cnt++;
            end
            check({v.name, " kind*1000+latency"}, int'(got_err) * 1000 + k,
                  int'(e.err) * 1000 + e.lat);
            check({v.name, " seen*1000+err_count"},
                  int'(TIMEOUT_SEEN) * 1000 + int'(ERR_COUNT), exp_seen * 1000 + exp_cnt);
            // Response must hold while AS stays low
            @(posedge CLK);
            @(negedge CLK);
            check({v.name, " hold {DTACK,BERR}"}, int'({DTACK, BERR}),
                  e.err ? 2 : 1);
        end
        release_bus();
        @(posedge CLK);
        @(negedge CLK);
        check({v.name, " release {DTACK,BERR}"}, int'({DTACK, BERR}), 3);
        $display("txn %0s: %0s after edge N+%0d, err_count=%0d", v.name,
                 !done ? "none" : (got_err ? "BERR" : "DTACK"), k, ERR_COUNT);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          name                  iack  romen ramen duart mfp   src at  tog   drop  err   lat
        vecs[0]  = '{"ram_ws0",           1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0,  1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{"rom_ws2",           1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0,  1'b0, 1'b0, 1'b0, 2};
        vecs[2]  = '{"rom_over_duart",    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0,  1'b0, 1'b0, 1'b0, 2};
        vecs[3]  = '{"duart_n4_mfp_tog",  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 4,  1'b1, 1'b0, 1'b0, 4};
        vecs[4]  = '{"mfp_sel_n2",        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 2,  1'b0, 1'b0, 1'b0, 2};
        vecs[5]  = '{"iack_n3",           1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 3,  1'b0, 1'b0, 1'b0, 3};
        vecs[6]  = '{"iack_n64_tie",      1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 64, 1'b0, 1'b0, 1'b0, 64};
        vecs[7]  = '{"unmapped",          1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0,  1'b0, 1'b0, 1'b1, 64};
        vecs[8]  = '{"duart_ign_mfp",     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2, 1,  1'b0, 1'b0, 1'b1, 64};
        vecs[9]  = '{"duart_min",         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0,  1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{"rom_sel_drop",      1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0,  1'b0, 1'b1, 1'b0, 2};
        vecs[11] = '{"iack_ign_duart",    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0,  1'b0, 1'b0, 1'b1, 64};

        // Power-on reset
        #2 RST = 1'b0;
        #1;
        check("reset {DTACK,BERR,SEEN}", int'({DTACK, BERR, TIMEOUT_SEEN}), 6);
        check("reset err_count", int'(ERR_COUNT), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 12; i++) run_cycle(vecs[i]);

        // Abort: ROM cycle (2 wait states) abandoned before its ack edge
        @(negedge CLK);
        ROMEN = 1'b0; AS = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("abort N+0 {DTACK,BERR}", int'({DTACK, BERR}), 3);
        AS = 1'b1; ROMEN = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("abort {DTACK,BERR}", int'({DTACK, BERR}), 3);
        end
        check("abort err_count", int'(ERR_COUNT), exp_cnt);
        $display("txn abort_rom: no response, err_count=%0d", ERR_COUNT);
        run_cycle(vecs[0]);

        // Saturation of the error counter
        for (int j = 0; j < 300; j++) run_cycle(vecs[7]);
        check("saturated err_count", int'(ERR_COUNT), 255);

        // Asynchronous reset in the middle of a WAIT
        @(negedge CLK);
        AS = 1'b0;
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        check("midwait reset {DTACK,BERR,SEEN}", int'({DTACK, BERR, TIMEOUT_SEEN}), 6);
        check("midwait reset err_count", int'(ERR_COUNT), 0);
        $display("txn reset_midwait: err_count=%0d", ERR_COUNT);
        exp_cnt = 0;
        exp_seen = 0;
        AS = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        run_cycle(vecs[1]);
        run_cycle(vecs[7]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
Bus cycle controller for the 68000 board. It sits between the address decoder's chip-select outputs and the CPU's DTACK/BERR pins. It sequences every bus cycle:
- internally timed DTACK with per-region wait states for ROM and RAM;
- pass-through of peripheral DTACK for DUART, MFP and interrupt-acknowledge cycles;
- bus-timeout BERR for any cycle that is not acknowledged in time.

Parameters:
ROM_WS, 2, wait states for ROM cycles (0..15)
RAM_WS, 0, wait states for RAM cycles (0..15)
TIMEOUT_CYCLES, 64, CLK edges from cycle start to BERR (2..255)

Ports:
CLK  input  1  system clock, same clock as CPU
RST  input  1  asynchronous active-low reset
AS  input  1  CPU address strobe, active low, synchronous to CLK
IACK  input  1  interrupt-acknowledge cycle indicator, active low
ROMEN  input  1  ROM select from decoder, active low
RAMEN  input  1  RAM select from decoder, active low
DUARTEN  input  1  DUART select from decoder, active low
MFPEN  input  1  MFP select from decoder, active low
DUART_DTACK_IN  input  1  DUART DTACK, active low
MFP_DTACK_IN  input  1  MFP DTACK (also used for its IACK vector cycles), active low
DTACK  output  1  registered DTACK to CPU, active low
BERR  output  1  registered bus error to CPU, active low
TIMEOUT_SEEN  output  1  sticky flag: at least one timeout since reset
ERR_COUNT  output  8  saturating count of BERR cycles since reset

Behaviour:
- All inputs are sampled on rising CLK. No synchronizers.
- Reset (RST low, asynchronous) forces state IDLE, DTACK=1, BERR=1, TIMEOUT_SEEN=0, ERR_COUNT=0, and clears all counters. Reset mid-cycle aborts the cycle with no ack.
- States: IDLE, WAIT, ACK, ERR. Outputs are decoded from registered state only: DTACK=0 only in ACK; BERR=0 only in ERR.
- Cycle start is edge N: first edge in IDLE with AS=0. The cycle class is latched at edge N, first match wins:
  1. IACK=0 → class EXT_MFP (select lines ignored)
  2. ROMEN=0 → class INT, wait count = ROM_WS
  3. RAMEN=0 → class INT, wait count = RAM_WS
  4. DUARTEN=0 → class EXT_DUART
  5. MFPEN=0 → class EXT_MFP
  6. none → class UNMAPPED
- INT cycle with wait count = 0: IDLE→ACK at edge N, so DTACK is low after edge N.
- INT cycle with wait count = W>0: IDLE→WAIT and load wait counter with W. Each WAIT edge decrements it. Move to ACK on the edge where the counter is 1. DTACK is low after edge N+W.
- EXT cycles: IDLE→WAIT. Move to ACK on the first WAIT edge where the selected DTACK_IN is 0. Minimum latency is DTACK low after edge N+1.
- UNMAPPED cycles: stay in WAIT until timeout.
- Timeout counter:
  - set to 1 at edge N, incremented on every WAIT edge;
  - on the WAIT edge where it would reach TIMEOUT_CYCLES with no ack condition, go WAIT→ERR, so BERR is low after edge N+TIMEOUT_CYCLES;
  - if the ack condition and timeout occur on the same edge, ack wins.
- Entering ERR sets TIMEOUT_SEEN=1 and increments ERR_COUNT, which saturates at 255.
- ACK and ERR are held while AS=0. The first edge with AS=1 returns to IDLE; DTACK/BERR deassert after that edge.
- A new cycle cannot start in the same edge as the return to IDLE (AS must be seen high first).
- Aborted cycle (AS=1 while in WAIT): return to IDLE, no DTACK, no BERR, no count change.
- Select or IACK changes after edge N are ignored. Only the latched class is used.
- Peripheral DTACK inputs are ignored outside WAIT of their own class.

Test Plan:
- RAM read, RAM_WS=0: AS low at edge 10 → DTACK low after edge 10. AS high at edge 13 → DTACK high after edge 13, BERR stays 1.
- ROM read, ROM_WS=2: AS low at edge 5 → DTACK low after edge 7, not earlier. Also check ROMEN=0 together with DUARTEN=0 resolves to ROM timing.
- DUART cycle: DUART_DTACK_IN low at edge N+4 → DTACK low after edge N+4. MFP_DTACK_IN toggling during the cycle has no effect.
- Unmapped access, TIMEOUT_CYCLES=64: BERR low after edge N+64; TIMEOUT_SEEN=1 and ERR_COUNT=1 until AS rises. Repeat 300 timeouts → ERR_COUNT=255.
- IACK cycle with MFPEN=1: MFP_DTACK_IN low at edge N+3 → DTACK low after edge N+3. Second run with the ack arriving exactly at edge N+64 → DTACK wins, BERR stays 1, ERR_COUNT unchanged.
- Abort and reset:
  - ROM cycle with ROM_WS=5, AS raised at N+2 → no DTACK, state returns to IDLE.
  - RST pulsed low mid-WAIT → DTACK=1, BERR=1, ERR_COUNT=0 immediately, before the next CLK edge.
